fp_addsub_seq: RTL and testbench



---
 rtl/fp_addsub_seq.sv | 261 ++++++++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor (default bfloat16) with valid/ready handshakes.
// Fixed latency: the result is valid on the 5th edge after accept, specials included.
module fp_addsub_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 7
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 op_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] sum,
    output logic [2:0]           flags
);
    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned SW = MAN_W + 5;
    localparam int unsigned DW = EXP_W + $clog2(MAN_W + 4);
    localparam int unsigned EW = DW + 1;
    localparam int unsigned LW = $clog2(SW);
    localparam logic [DW-1:0] MaxShift = DW'(MAN_W + 3);
    localparam int ExpMax = (1 << EXP_W) - 1;
    localparam logic [EXP_W-1:0] ExpOnes = '1;
    localparam logic [W-1:0] CanonNan = {1'b0, ExpOnes, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [EW-1:0] ExpOne = EW'(1);

    typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StRound, StDone} state_e;

    state_e state_q, state_d;
    logic   out_valid_q;

    logic                   sgn_a_q, sgn_b_q;
    logic [EXP_W-1:0]       exp_a_q, exp_b_q;
    logic [MAN_W-1:0]       frac_a_q, frac_b_q;
    logic                   spec_q;
    logic [W-1:0]           spec_sum_q;
    logic [2:0]             spec_flags_q;
    logic [SW-1:0]          sig_x_q, sig_y_q;
    logic                   sgn_x_q, sgn_y_q;
    logic signed [EW-1:0]   exp_q;
    logic [SW-1:0]          res_sig_q;
    logic                   res_sgn_q;
    logic [W-1:0]           sum_q;
    logic [2:0]             flags_q;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign flags     = flags_q;

    // Operand classification at accept; subnormals count as zero.
    logic         sgn_b_eff, zero_a, zero_b, nan_a, nan_b, inf_a, inf_b;
    logic         spec_d;
    logic [W-1:0] spec_sum_d;
    logic [2:0]   spec_flags_d;

    always_comb begin
        sgn_b_eff    = b[W-1] ^ op_sub;
        zero_a       = (a[W-2:MAN_W] == '0);
        zero_b       = (b[W-2:MAN_W] == '0);
        nan_a        = (a[W-2:MAN_W] == ExpOnes) && (a[MAN_W-1:0] != '0);
        nan_b        = (b[W-2:MAN_W] == ExpOnes) && (b[MAN_W-1:0] != '0);
        inf_a        = (a[W-2:MAN_W] == ExpOnes) && (a[MAN_W-1:0] == '0);
        inf_b        = (b[W-2:MAN_W] == ExpOnes) && (b[MAN_W-1:0] == '0);
        spec_d       = 1'b1;
        spec_sum_d   = '0;
        spec_flags_d = 3'b000;
        if (nan_a || nan_b) begin
            spec_sum_d = CanonNan;
        end else if (inf_a && inf_b && (a[W-1] != sgn_b_eff)) begin
            spec_sum_d   = CanonNan;
            spec_flags_d = 3'b100;
        end else if (inf_a) begin
            spec_sum_d = a;
        end else if (inf_b) begin
            spec_sum_d = {sgn_b_eff, b[W-2:0]};
        end else if (zero_a && zero_b) begin
            spec_sum_d = {a[W-1] & sgn_b_eff, {(W-1){1'b0}}};
        end else if (zero_a) begin
            spec_sum_d = {sgn_b_eff, b[W-2:0]};
        end else if (zero_b) begin
            spec_sum_d = a;
        end else begin
            spec_d = 1'b0;
        end
    end

    // Alignment: shifted-out bits collapse into the sticky LSB.
    logic              a_big;
    logic [EXP_W-1:0]  diff;
    logic [DW-1:0]     diff_w, shamt;
    logic [SW-1:0]     sig_big, sig_small, sig_aligned;
    logic [2*SW-1:0]   shifted;

    always_comb begin
        a_big       = (exp_a_q >= exp_b_q);
        diff        = a_big ? (exp_a_q - exp_b_q) : (exp_b_q - exp_a_q);
        diff_w      = {{(DW-EXP_W){1'b0}}, diff};
        shamt       = (diff_w > MaxShift) ? MaxShift : diff_w;
        sig_big     = {2'b01, (a_big ? frac_a_q : frac_b_q), 3'b000};
        sig_small   = {2'b01, (a_big ? frac_b_q : frac_a_q), 3'b000};
        shifted     = {sig_small, {SW{1'b0}}} >> shamt;
        sig_aligned = shifted[2*SW-1:SW] | {{(SW-1){1'b0}}, |shifted[SW-1:0]};
    end

    logic [SW-1:0] add_sig;
    logic          add_sgn;

    always_comb begin
        add_sig = sig_x_q + sig_y_q;
        add_sgn = sgn_x_q;
        if (sgn_x_q != sgn_y_q) begin
            if (sig_x_q >= sig_y_q) begin
                add_sig = sig_x_q - sig_y_q;
            end else begin
                add_sig = sig_y_q - sig_x_q;
                add_sgn = sgn_y_q;
            end
        end
    end

    logic [LW-1:0]        lz;
    logic [SW-1:0]        norm_sig;
    logic signed [EW-1:0] norm_exp;

    always_comb begin
        lz = '0;
        for (int i = 0; i < SW - 1; i++) begin
            if (res_sig_q[i]) lz = LW'(SW - 2 - i);
        end
        norm_sig = res_sig_q;
        norm_exp = exp_q;
        if (res_sig_q[SW-1]) begin
            norm_sig = {1'b0, res_sig_q[SW-1:2], res_sig_q[1] | res_sig_q[0]};
            norm_exp = exp_q + ExpOne;
        end else if (res_sig_q != '0) begin
            norm_sig = res_sig_q << lz;
            norm_exp = exp_q - EW'(lz);
        end
    end

    logic [MAN_W:0]       mant;
    logic                 grd, rnd, stk, inexact, up;
    logic [MAN_W+1:0]     mant_r;
    logic signed [EW-1:0] exp_r;
    logic [W-1:0]         rnd_sum;
    logic [2:0]           rnd_flags;

    always_comb begin
        mant      = res_sig_q[SW-2:3];
        grd       = res_sig_q[2];
        rnd       = res_sig_q[1];
        stk       = res_sig_q[0];
        inexact   = grd | rnd | stk;
        up        = grd & (rnd | stk | mant[0]);
        mant_r    = {1'b0, mant} + {{(MAN_W+1){1'b0}}, up};
        exp_r     = exp_q + EW'(mant_r[MAN_W+1]);
        rnd_flags = {2'b00, inexact};
        rnd_sum   = {res_sgn_q, exp_r[EXP_W-1:0],
                     (mant_r[MAN_W+1] ? {MAN_W{1'b0}} : mant_r[MAN_W-1:0])};
        if (spec_q) begin
            rnd_sum   = spec_sum_q;
            rnd_flags = spec_flags_q;
        end else if (res_sig_q == '0) begin
            // Exact cancellation always yields +0.
            rnd_sum   = '0;
            rnd_flags = 3'b000;
        end else if (int'(exp_r) >= ExpMax) begin
            rnd_sum   = {res_sgn_q, ExpOnes, {MAN_W{1'b0}}};
            rnd_flags = 3'b011;
        end else if (int'(exp_r) <= 0) begin
            rnd_sum   = {res_sgn_q, {(W-1){1'b0}}};
            rnd_flags = 3'b001;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StAlign;
            StAlign: state_d = StAdd;
            StAdd:   state_d = StNorm;
            StNorm:  state_d = StRound;
            StRound: state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == StDone);
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            sgn_a_q      <= 1'b0;
            sgn_b_q      <= 1'b0;
            exp_a_q      <= '0;
            exp_b_q      <= '0;
            frac_a_q     <= '0;
            frac_b_q     <= '0;
            spec_q       <= 1'b0;
            spec_sum_q   <= '0;
            spec_flags_q <= '0;
            sig_x_q      <= '0;
            sig_y_q      <= '0;
            sgn_x_q      <= 1'b0;
            sgn_y_q      <= 1'b0;
            exp_q        <= '0;
            res_sig_q    <= '0;
            res_sgn_q    <= 1'b0;
            sum_q        <= '0;
            flags_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        sgn_a_q      <= a[W-1];
                        sgn_b_q      <= sgn_b_eff;
                        exp_a_q      <= a[W-2:MAN_W];
                        exp_b_q      <= b[W-2:MAN_W];
                        frac_a_q     <= a[MAN_W-1:0];
                        frac_b_q     <= b[MAN_W-1:0];
                        spec_q       <= spec_d;
                        spec_sum_q   <= spec_sum_d;
                        spec_flags_q <= spec_flags_d;
                    end
                end
                StAlign: begin
                    sig_x_q <= sig_big;
                    sig_y_q <= sig_aligned;
                    sgn_x_q <= a_big ? sgn_a_q : sgn_b_q;
                    sgn_y_q <= a_big ? sgn_b_q : sgn_a_q;
                    exp_q   <= EW'(a_big ? exp_a_q : exp_b_q);
                end
                StAdd: begin
                    res_sig_q <= add_sig;
                    res_sgn_q <= add_sgn;
                end
                StNorm: begin
                    res_sig_q <= norm_sig;
                    exp_q     <= norm_exp;
                end
                StRound: begin
                    sum_q   <= rnd_sum;
                    flags_q <= rnd_flags;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq: bfloat16 and half-precision instances share stimulus and are
// checked against an exact-arithmetic reference model plus directed vectors.
module tb_fp_addsub_seq;
    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic        in_valid = 1'b0;
    logic        op_sub = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic        in_ready_bf, out_valid_bf, in_ready_hp, out_valid_hp;
    logic [15:0] sum_bf, sum_hp;
    logic [2:0]  flags_bf, flags_hp;

    int n_checks = 0;
    int n_fail = 0;

    logic [15:0] r_sum[2];
    logic [2:0]  r_flags[2];
    int          r_lat;

    always #5 clock = ~clock;

    fp_addsub_seq dut_bf (
        .clock(clock), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready_bf),
        .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid_bf), .out_ready(out_ready),
        .sum(sum_bf), .flags(flags_bf)
    );

    fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut_hp (
        .clock(clock), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready_hp),
        .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid_hp), .out_ready(out_ready),
        .sum(sum_hp), .flags(flags_hp)
    );

    typedef logic [299:0] big_t;

    // Exact reference: operands become wide integers, result rounded RNE from the true value.
    function automatic logic [18:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic sub, input int ew, input int mw);
        int emax, fmask, xi, yi, ex, ey, fx, fy, qnan, p, e, sh, res;
        logic sx, sy, s, inx;
        big_t mx, my, mag, q, rem, half;
        emax  = (1 << ew) - 1;
        fmask = (1 << mw) - 1;
        xi    = int'(x);
        yi    = int'(y);
        sx    = x[15];
        sy    = y[15] ^ sub;
        ex    = (xi >> mw) & emax;
        ey    = (yi >> mw) & emax;
        fx    = xi & fmask;
        fy    = yi & fmask;
        qnan  = (emax << mw) | (1 << (mw - 1));
        if ((ex == emax && fx != 0) || (ey == emax && fy != 0)) return {3'b000, 16'(qnan)};
        if (ex == emax && ey == emax && sx != sy) return {3'b100, 16'(qnan)};
        if (ex == emax) return {3'b000, sx, 15'(emax << mw)};
        if (ey == emax) return {3'b000, sy, 15'(emax << mw)};
        if (ex == 0 && ey == 0) return {3'b000, sx & sy, 15'd0};
        if (ex == 0) return {3'b000, sy, y[14:0]};
        if (ey == 0) return {3'b000, x};
        mx = big_t'(fx | (1 << mw)) << (ex - 1);
        my = big_t'(fy | (1 << mw)) << (ey - 1);
        if (sx == sy) begin
            mag = mx + my;
            s   = sx;
        end else if (mx >= my) begin
            mag = mx - my;
            s   = sx;
        end else begin
            mag = my - mx;
            s   = sy;
        end
        if (mag == 0) return 19'd0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e   = p - mw + 1;
        inx = 1'b0;
        if (p > mw) begin
            sh   = p - mw;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = big_t'(1) << (sh - 1);
            inx  = (rem != 0);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end else begin
            q = mag << (mw - p);
        end
        if (q[mw + 1]) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= emax) return {3'b011, s, 15'(emax << mw)};
        if (e <= 0) return {3'b001, s, 15'd0};
        res = (e << mw) | (int'(q[15:0]) & fmask);
        return {2'b00, inx, s, res[14:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Accepts one op on both instances, waits (bounded) for the result, then takes it.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts);
        int guard = 0;
        while (!in_ready_bf && guard < 20) begin
            @(posedge clock); #1;
            guard++;
        end
        a = ta; b = tb; op_sub = ts; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        r_lat = 1;
        while (!(out_valid_bf && out_valid_hp) && r_lat < 20) begin
            @(posedge clock); #1;
            r_lat++;
        end
        r_sum[0] = sum_bf; r_flags[0] = flags_bf;
        r_sum[1] = sum_hp; r_flags[1] = flags_hp;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] sum;
        logic [2:0]  flags;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{16'h3F80, 16'h4000, 1'b0, 16'h4040, 3'b000};
        vecs[1]  = '{16'h3F80, 16'h3F80, 1'b1, 16'h0000, 3'b000};
        vecs[2]  = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000};
        vecs[3]  = '{16'h3F80, 16'h3B80, 1'b0, 16'h3F80, 3'b001};
        vecs[4]  = '{16'h3F81, 16'h3B80, 1'b0, 16'h3F82, 3'b001};
        vecs[5]  = '{16'h7F80, 16'hFF80, 1'b0, 16'h7FC0, 3'b100};
        vecs[6]  = '{16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0, 3'b000};
        vecs[7]  = '{16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, 3'b011};
        vecs[8]  = '{16'h4040, 16'h3F80, 1'b1, 16'h4000, 3'b000};
        vecs[9]  = '{16'h0001, 16'h3F80, 1'b0, 16'h3F80, 3'b000};
        vecs[10] = '{16'h3F80, 16'h4000, 1'b1, 16'hBF80, 3'b000};
        vecs[11] = '{16'h0080, 16'h0081, 1'b1, 16'h8000, 3'b001};
        vecs[12] = '{16'h7F80, 16'h7F80, 1'b1, 16'h7FC0, 3'b100};
        vecs[13] = '{16'h3F80, 16'h0000, 1'b1, 16'h3F80, 3'b000};

        #3;
        check("rst_in_ready", {31'd0, in_ready_bf}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid_bf}, 32'd0);
        check("rst_sum", {16'd0, sum_bf}, 32'd0);
        check("rst_flags", {29'd0, flags_bf}, 32'd0);
        #9 nreset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub);
            check($sformatf("vec%0d_sum", i), {16'd0, r_sum[0]}, {16'd0, vecs[i].sum});
            check($sformatf("vec%0d_flags", i), {29'd0, r_flags[0]}, {29'd0, vecs[i].flags});
            check($sformatf("vec%0d_latency", i), r_lat, 5);
            check($sformatf("vec%0d_hp", i), {13'd0, r_flags[1], r_sum[1]},
                  {13'd0, ref_add(vecs[i].a, vecs[i].b, vecs[i].sub, 5, 10)});
        end

        run_op(16'h3C00, 16'h4000, 1'b0);
        check("hp_one_plus_two", {13'd0, r_flags[1], r_sum[1]}, {13'd0, 3'b000, 16'h4200});

        // Backpressure: result held, new requests ignored.
        a = 16'h3F80; b = 16'h4000; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        r_lat = 1;
        while (!out_valid_bf && r_lat < 20) begin
            @(posedge clock); #1;
            r_lat++;
        end
        check("bp_latency", r_lat, 5);
        a = 16'h4000; b = 16'h4000; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            check("bp_out_valid", {31'd0, out_valid_bf}, 32'd1);
            check("bp_sum", {16'd0, sum_bf}, 32'h4040);
            check("bp_flags", {29'd0, flags_bf}, 32'd0);
            check("bp_in_ready", {31'd0, in_ready_bf}, 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("bp_release_valid", {31'd0, out_valid_bf}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready_bf}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            check("bp_no_ghost_op", {31'd0, out_valid_bf}, 32'd0);
        end

        // Reset while the operation sits in NORM.
        a = 16'h4040; b = 16'h3F80; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock); #1;
        nreset = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid_bf}, 32'd0);
        check("mid_rst_sum", {16'd0, sum_bf}, 32'd0);
        check("mid_rst_flags", {29'd0, flags_bf}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready_bf}, 32'd1);
        check("mid_rst_hp_sum", {16'd0, sum_hp}, 32'd0);
        @(posedge clock); #2;
        nreset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            check("post_rst_idle", {30'd0, out_valid_bf, in_ready_bf}, 32'd1);
        end
        run_op(16'h3F80, 16'h4000, 1'b0);
        check("post_rst_sum", {13'd0, r_flags[0], r_sum[0]}, {13'd0, 3'b000, 16'h4040});
        check("post_rst_latency", r_lat, 5);

        for (int i = 0; i < 300; i++) begin
            logic [15:0] ra, rb;
            logic        rs;
            ra = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: rb = 16'($urandom);
                1: rb = ra ^ 16'($urandom_range(0, 511));
                default: rb = ra;
            endcase
            run_op(ra, rb, rs);
            check($sformatf("rand_bf %h %h %0d", ra, rb, rs), {13'd0, r_flags[0], r_sum[0]},
                  {13'd0, ref_add(ra, rb, rs, 8, 7)});
            check($sformatf("rand_hp %h %h %0d", ra, rb, rs), {13'd0, r_flags[1], r_sum[1]},
                  {13'd0, ref_add(ra, rb, rs, 5, 10)});
            check("rand_latency", r_lat, 5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
